// File: rtl/sd_cmd_pkg.sv
// ---------------------------------------------------------------------------
// sd_cmd_pkg
//   Shared definitions for the SD command-line response path: receiver
//   state encoding, frame sizes, the response timeout default and the
//   CRC7 polynomial with its single-bit update step.
// ---------------------------------------------------------------------------
package sd_cmd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_WAIT_START,
      ST_RECEIVE,
      ST_CHECK
   } state_e;

   // Frame sizes expressed as (frame bits - 1), i.e. the index of the start bit.
   localparam int unsigned R1_FRAMESIZE = 47;
   localparam int unsigned R2_FRAMESIZE = 135;

   // Default number of clocks allowed between arming and the start bit.
   localparam int unsigned NCR_MAX = 64;

   // CRC7 coverage: short frames cover [47:8]; long frames only [127:8]
   // (start, transmission and reserved bits of R2 are not protected).
   localparam int unsigned CRC_LO_BIT = 8;
   localparam int unsigned R2_CRC_HI  = 127;

   // x^7 + x^3 + 1, without the implicit x^7 term.
   localparam logic [6:0] CRC7_POLY = 7'h09;

   function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic bit_in);
      logic fb;
      fb = crc[6] ^ bit_in;
      return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
   endfunction

endpackage

// File: rtl/sd_crc7_serial.sv
// ---------------------------------------------------------------------------
// sd_crc7_serial
//   Bit-serial CRC7 accumulator (x^7 + x^3 + 1, init 0). Used by the CMD
//   response receiver and intended for reuse by the CMD transmitter.
// Ports
//   clk     in   clock, posedge
//   reset   in   asynchronous, active-high; clears the CRC
//   clear   in   synchronous clear to 0 (has priority over en)
//   en      in   fold bit_in into the CRC this clock
//   bit_in  in   serial data bit, MSB of the message first
//   crc     out  current CRC7 remainder
// ---------------------------------------------------------------------------
module sd_crc7_serial (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       en,
   input  logic       bit_in,
   output logic [6:0] crc
);
   import sd_cmd_pkg::*;

   logic [6:0] crc_q;
   logic [6:0] crc_d;

   always_comb begin
      crc_d = crc_q;
      if (clear) begin
         crc_d = '0;
      end else if (en) begin
         crc_d = crc7_next(crc_q, bit_in);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_response_receiver.sv
// ---------------------------------------------------------------------------
// sd_cmd_response_receiver
//   Arms on request and watches the SD CMD line for a response start bit.
//   Once found, the frame is streamed into the command-line deserializer
//   (deser_in / deser_enable), one registered cycle behind cmd_in, while
//   CRC7, the transmission bit and the end bit are checked serially. A
//   one-cycle done pulse with error flags is returned to the command FSM.
// Parameters
//   NCR_MAX          clocks allowed in WAIT_START before timeout
//   CNT_W            width of bit counter and framesize bus
// Ports
//   clk              in   SD clock, posedge
//   reset            in   asynchronous, active-high
//   start            in   1-cycle arm pulse; ignored while busy
//   long_resp        in   1 = 136-bit R2 frame, 0 = 48-bit; latched on start
//   crc_check_en     in   0 = skip CRC compare (R3); latched on start
//   cmd_in           in   raw CMD line
//   deser_in         out  registered copy of cmd_in
//   deser_enable     out  high while a frame bit is on deser_in
//   deser_reset      out  1-cycle pulse after start
//   deser_framesize  out  frame bits - 1 (135 or 47)
//   deser_complete   in   deserializer frame-complete flag
//   busy             out  receiver not idle
//   done             out  1-cycle pulse at end of frame or timeout
//   timeout_err      out  no start bit within NCR_MAX clocks
//   crc_err          out  computed CRC7 differs from received bits [7:1]
//   tx_err           out  transmission bit was 1
//   end_err          out  end bit was 0
//   sync_err         out  deserializer not complete when checked
// ---------------------------------------------------------------------------
module sd_cmd_response_receiver #(
   parameter int unsigned NCR_MAX = sd_cmd_pkg::NCR_MAX,
   parameter int unsigned CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             long_resp,
   input  logic             crc_check_en,
   input  logic             cmd_in,
   output logic             deser_in,
   output logic             deser_enable,
   output logic             deser_reset,
   output logic [CNT_W-1:0] deser_framesize,
   input  logic             deser_complete,
   output logic             busy,
   output logic             done,
   output logic             timeout_err,
   output logic             crc_err,
   output logic             tx_err,
   output logic             end_err,
   output logic             sync_err
);
   import sd_cmd_pkg::*;

   localparam int unsigned NCR_W = (NCR_MAX > 1) ? $clog2(NCR_MAX) : 1;
   localparam logic [NCR_W-1:0] NCR_LAST = NCR_W'(NCR_MAX - 1);

   state_e           state_q, state_d;
   logic             cmd_q, cmd_d;
   logic             long_q, long_d;
   logic             crc_en_q, crc_en_d;
   logic [CNT_W-1:0] framesize_q, framesize_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [NCR_W-1:0] ncr_cnt_q, ncr_cnt_d;
   logic [6:0]       crc_rx_q, crc_rx_d;
   logic             enable_q, enable_d;
   logic             dreset_q, dreset_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             timeout_q, timeout_d;
   logic             crc_err_q, crc_err_d;
   logic             tx_err_q, tx_err_d;
   logic             end_err_q, end_err_d;
   logic             sync_err_q, sync_err_d;

   logic [CNT_W-1:0] crc_hi;
   logic             crc_clear;
   logic             crc_step;
   logic [6:0]       crc_calc;

   // CRC coverage window and accumulator control.
   always_comb begin
      crc_hi    = long_q ? CNT_W'(R2_CRC_HI) : CNT_W'(R1_FRAMESIZE);
      crc_clear = (state_q == ST_IDLE) && start;
      crc_step  = (state_q == ST_RECEIVE) &&
                  (bit_cnt_q <= crc_hi) && (bit_cnt_q >= CNT_W'(CRC_LO_BIT));
   end

   sd_crc7_serial u_crc7 (
      .clk    (clk),
      .reset  (reset),
      .clear  (crc_clear),
      .en     (crc_step),
      .bit_in (cmd_q),
      .crc    (crc_calc)
   );

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_in;
      long_d      = long_q;
      crc_en_d    = crc_en_q;
      framesize_d = framesize_q;
      bit_cnt_d   = bit_cnt_q;
      ncr_cnt_d   = ncr_cnt_q;
      crc_rx_d    = crc_rx_q;
      enable_d    = enable_q;
      dreset_d    = 1'b0;
      done_d      = 1'b0;
      timeout_d   = timeout_q;
      crc_err_d   = crc_err_q;
      tx_err_d    = tx_err_q;
      end_err_d   = end_err_q;
      sync_err_d  = sync_err_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               long_d      = long_resp;
               crc_en_d    = crc_check_en;
               framesize_d = long_resp ? CNT_W'(R2_FRAMESIZE) : CNT_W'(R1_FRAMESIZE);
               timeout_d   = 1'b0;
               crc_err_d   = 1'b0;
               tx_err_d    = 1'b0;
               end_err_d   = 1'b0;
               sync_err_d  = 1'b0;
               crc_rx_d    = '0;
               dreset_d    = 1'b1;
               state_d     = ST_ARM;
            end
         end

         ST_ARM: begin
            ncr_cnt_d = '0;
            state_d   = ST_WAIT_START;
         end

         ST_WAIT_START: begin
            // The start bit is detected as it is captured into cmd_q, so the
            // enable rises together with the start bit appearing on deser_in.
            if (!cmd_in) begin
               enable_d  = 1'b1;
               bit_cnt_d = framesize_q;
               state_d   = ST_RECEIVE;
            end else if (ncr_cnt_q == NCR_LAST) begin
               timeout_d = 1'b1;
               done_d    = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               ncr_cnt_d = ncr_cnt_q + NCR_W'(1);
            end
         end

         ST_RECEIVE: begin
            if (bit_cnt_q == framesize_q - CNT_W'(1)) begin
               tx_err_d = tx_err_q | cmd_q;
            end
            if ((bit_cnt_q <= CNT_W'(7)) && (bit_cnt_q >= CNT_W'(1))) begin
               crc_rx_d = {crc_rx_q[5:0], cmd_q};
            end
            if (bit_cnt_q == '0) begin
               end_err_d = ~cmd_q;
               enable_d  = 1'b0;
               state_d   = ST_CHECK;
            end else begin
               bit_cnt_d = bit_cnt_q - CNT_W'(1);
            end
         end

         ST_CHECK: begin
            crc_err_d  = crc_en_q & (crc_calc != crc_rx_q);
            sync_err_d = ~deser_complete;
            done_d     = 1'b1;
            state_d    = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cmd_q       <= 1'b1;
         long_q      <= 1'b0;
         crc_en_q    <= 1'b0;
         framesize_q <= '0;
         bit_cnt_q   <= '0;
         ncr_cnt_q   <= '0;
         crc_rx_q    <= '0;
         enable_q    <= 1'b0;
         dreset_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
         crc_err_q   <= 1'b0;
         tx_err_q    <= 1'b0;
         end_err_q   <= 1'b0;
         sync_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         long_q      <= long_d;
         crc_en_q    <= crc_en_d;
         framesize_q <= framesize_d;
         bit_cnt_q   <= bit_cnt_d;
         ncr_cnt_q   <= ncr_cnt_d;
         crc_rx_q    <= crc_rx_d;
         enable_q    <= enable_d;
         dreset_q    <= dreset_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         timeout_q   <= timeout_d;
         crc_err_q   <= crc_err_d;
         tx_err_q    <= tx_err_d;
         end_err_q   <= end_err_d;
         sync_err_q  <= sync_err_d;
      end
   end

   assign deser_in        = cmd_q;
   assign deser_enable    = enable_q;
   assign deser_reset     = dreset_q;
   assign deser_framesize = framesize_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign timeout_err     = timeout_q;
   assign crc_err         = crc_err_q;
   assign tx_err          = tx_err_q;
   assign end_err         = end_err_q;
   assign sync_err        = sync_err_q;

endmodule
